mips_muldiv_seq: RTL and testbench

Multi-cycle multiply sequencer that owns the Lo/Hi register pair for mult/multu and mflo/mfhi. Accepts a multiply request decoded in ID and runs a radix-2 shift-add iteration over WIDTH cycles. Raises a pipeline stall when mflo/mfhi or a second mult reaches ID while an operation is in flight. Sits beside the ALU in EX; the controller drives start/rd_lo/rd_hi and the hazard logic consumes stall.

---
 rtl/mips_muldiv_pkg.sv | 17 +
 rtl/mips_muldiv_dp.sv | 75 +++++++
 rtl/mips_muldiv_seq.sv | 95 +++++++++
 tb/tb_mips_muldiv_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the mult/multu sequencer: state encoding, default
// operand width and the iteration-counter width helper.
package mips_muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    typedef logic [1:0] muldiv_state_t;

    localparam muldiv_state_t IDLE = 2'd0;
    localparam muldiv_state_t RUN  = 2'd1;
    localparam muldiv_state_t FIX  = 2'd2;

    function automatic int muldiv_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mips_muldiv_dp.sv
// Shift-add multiply datapath: operand magnitudes, accumulator, carry-keeping
// adder, right shifter and the final sign fix that loads Lo/Hi.
module mips_muldiv_dp
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH      = MULDIV_WIDTH,
    parameter int CNT_W      = muldiv_cnt_w(WIDTH),
    parameter bit EARLY_TERM = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [CNT_W-1:0] cnt,
    output logic             rest_zero,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic               sign;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] acc_next;
    logic [CNT_W-1:0]   rem;

    // The most negative input maps onto itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        logic signed [WIDTH-1:0] vs;
        vs = v;
        return (is_signed && vs < 0) ? WIDTH'(-vs) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    assign rest_zero = ~|mplier[WIDTH-1:1];
    assign sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
    assign acc_step  = {sum, acc[WIDTH-1:1]};
    assign rem       = CNT_W'(WIDTH - 1) - cnt;
    assign acc_next  = (EARLY_TERM && rest_zero) ? (acc_step >> rem) : acc_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            sign   <= 1'b0;
            lo     <= '0;
            hi     <= '0;
        end else begin
            if (load) begin
                mcand  <= magnitude(op_a, signed_op);
                mplier <= magnitude(op_b, signed_op);
                sign   <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                acc    <= '0;
            end else if (step) begin
                acc    <= acc_next;
                mplier <= mplier >> 1;
            end
            if (fix) begin
                {hi, lo} <= sign ? negate(acc) : acc;
            end
        end
    end

endmodule

// File: rtl/mips_muldiv_seq.sv
// Multi-cycle mult/multu sequencer owning Lo/Hi, with ID-stage stall generation.
// Define MIPS_MULDIV_EARLY_TERM_EN to finish RUN once the remaining multiplier bits are zero.
module mips_muldiv_seq
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH,
    parameter int CNT_W = muldiv_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic             rd_lo,
    input  logic             rd_hi,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

`ifdef MIPS_MULDIV_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    muldiv_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             step;
    logic             fix;
    logic             last;
    logic             rest_zero;

    assign busy  = (state != IDLE);
    assign stall = busy & (rd_lo | rd_hi | start);

    // A flush on the issuing instruction squashes acceptance and any further progress.
    assign load = (state == IDLE) & start & ~flush;
    assign step = (state == RUN) & ~flush;
    assign fix  = (state == FIX) & ~flush;
    assign last = (cnt == CNT_W'(WIDTH - 1)) | (EARLY_TERM & rest_zero);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= fix;
            case (state)
                IDLE: begin
                    if (load) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (last) state <= FIX;
                    end
                end
                FIX:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    mips_muldiv_dp #(
        .WIDTH      (WIDTH),
        .CNT_W      (CNT_W),
        .EARLY_TERM (EARLY_TERM)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .fix       (fix),
        .signed_op (signed_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .cnt       (cnt),
        .rest_zero (rest_zero),
        .lo        (lo),
        .hi        (hi)
    );

endmodule

// File: tb/tb_mips_muldiv_seq.sv
// Scoreboard bench for mips_muldiv_seq: products and done timing come from plain
// 64-bit arithmetic; a negedge monitor pops expectations on every done pulse.
module tb_mips_muldiv_seq;

    localparam int W = 32;

`ifdef MIPS_MULDIV_EARLY_TERM_EN
    localparam bit ET_BUILD = 1'b1;
`else
    localparam bit ET_BUILD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         signed_op;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         flush;
    logic         rd_lo;
    logic         rd_hi;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] lo;
    logic [W-1:0] hi;

    mips_muldiv_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .rd_lo     (rd_lo),
        .rd_hi     (rd_hi),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .lo        (lo),
        .hi        (hi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] prod;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint      x;
        longint      y;
        logic [63:0] ua;
        logic [63:0] ub;
        x  = longint'($signed(a));
        y  = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        return s ? 64'(x * y) : ua * ub;
    endfunction

    // Busy cycles per operation: WIDTH RUN cycles plus FIX, or with early termination
    // (highest set bit of |multiplier| + 1) RUN cycles plus FIX.
    function automatic int exp_busy(input logic [31:0] b, input logic s);
        logic [31:0] m;
        int          n_et;
        m    = (s && b[31]) ? (~b + 32'd1) : b;
        n_et = 2;
        for (int i = 0; i < W; i++) if (m[i]) n_et = i + 2;
        return ET_BUILD ? n_et : W + 1;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("product_hilo", {hi, lo}, e.prod);
                chk("done_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Holds start (checking stall while busy) until the next edge accepts it.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit push);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; signed_op = s;
        #1;
        while (busy === 1'b1) begin
            chk("stall_start_held", stall, 1);
            @(negedge clk); #1;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 0, 1);
                start = 1'b0;
                return;
            end
        end
        if (push) begin
            e.prod = model(a, b, s);
            e.due  = cyc + 1 + exp_busy(b, s);
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_n, input string nm);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            if (rd_lo | rd_hi) chk("stall_rd_busy", stall, 1);
            n++;
            @(negedge clk);
        end
        chk(nm, n, exp_n);
        chk("stall_after_done", stall, 0);
    endtask

    logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic        s;
        logic [63:0] p;
        int          bad;

        rst = 1'b1; start = 1'b1; flush = 1'b0; rd_lo = 1'b1; rd_hi = 1'b0;
        op_a = 32'd3; op_b = 32'd4; signed_op = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_lo", lo, 0);
        chk("rst_hi", hi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 0);
        rst = 1'b0; start = 1'b0; rd_lo = 1'b0;

        issue(32'd7, 32'd6, 1'b0, 1'b1);
        wait_done(ET_BUILD ? 4 : 33, "busy_7x6");
        chk("multu_7x6", {hi, lo}, 64'd42);

        issue(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1);
        wait_done(ET_BUILD ? 4 : 33, "busy_m3x5");
        chk("mult_m3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        wait_done(33, "busy_minxmin");
        chk("mult_minxmin", {hi, lo}, 64'h4000_0000_0000_0000);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_done(33, "busy_maxxmax");
        chk("multu_maxxmax", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        issue(32'd9, 32'd6, 1'b0, 1'b1);
        wait_done(ET_BUILD ? 4 : 33, "busy_9x6");
        chk("multu_9x6", {hi, lo}, 64'd54);

        // mflo held in ID from the cycle after start
        issue(32'h0001_2345, 32'hFFFF_FF00, 1'b1, 1'b1);
        rd_lo = 1'b1;
        wait_done(exp_busy(32'hFFFF_FF00, 1'b1), "busy_mflo");
        p = model(32'h0001_2345, 32'hFFFF_FF00, 1'b1);
        chk("mflo_value", lo, {32'b0, p[31:0]});
        rd_lo = 1'b0;

        // back-to-back: second start is stalled, then accepted
        issue(32'd1000, 32'd3000, 1'b0, 1'b1);
        issue(32'hFFFF_FF85, 32'h0000_0400, 1'b1, 1'b1);
        wait_done(exp_busy(32'h0000_0400, 1'b1), "busy_b2b");
        p = model(32'hFFFF_FF85, 32'h0000_0400, 1'b1);
        chk("b2b_value", {hi, lo}, p);

        // lo=42 then flush at RUN count 10
        issue(32'd7, 32'd6, 1'b0, 1'b1);
        wait_done(exp_busy(32'd6, 1'b0), "busy_pre_flush");
        issue(32'd3, 32'h8000_0005, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_lo", lo, 42);
        chk("flush_hi", hi, 0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("flush_no_done", bad, 0);

        // reset at RUN count 5
        issue(32'h1234, 32'h8000_0007, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_lo", lo, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_busy", busy, 0);

        for (int k = 0; k < 25; k++) begin
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
            s = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(a, b, s, 1'b1);
            rd_lo = 1'($urandom_range(0, 1));
            rd_hi = 1'($urandom_range(0, 1));
            wait_done(exp_busy(b, s), "busy_rand");
            p = model(a, b, s);
            if (rd_lo) chk("rand_mflo", lo, {32'b0, p[31:0]});
            if (rd_hi) chk("rand_mfhi", hi, {32'b0, p[63:32]});
            rd_lo = 1'b0;
            rd_hi = 1'b0;
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
